sobel_window_sequencer: RTL

- Parametrised successor to the fixed 3x3 Sobel controller.
- Sequences a KSIZE x KSIZE sliding-window walk over an IMG_W x IMG_H image stored in memory. At each output position it fetches pixels, triggers the gradient datapath, and writes one result.
- Refetches the full window only at the start of each row; elsewhere it shifts the window and fetches only the new column.
- Sits between the memory read/write ports and the window-register/gradient datapath. Adds abort, an address generator and frame completion, none of which the fixed controller had.

---
 rtl/sobel_window_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/sobel_window_sequencer.sv
// rtl/sobel_window_sequencer.sv - KSIZE x KSIZE sliding-window fetch/calc/write sequencer
// Walks output centres in raster order; full window refetch at row start, one new column elsewhere.
module sobel_window_sequencer #(
  parameter int                KSIZE    = 3,
  parameter int                IMG_W    = 8,
  parameter int                IMG_H    = 8,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] IN_BASE  = '0,
  parameter logic [ADDR_W-1:0] OUT_BASE = 16'h8000
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_ack,
  output logic                     win_wr_en,
  output logic [$clog2(KSIZE)-1:0] win_row,
  output logic [$clog2(KSIZE)-1:0] win_col,
  output logic                     win_shift,
  output logic                     calc_start,
  input  logic                     calc_done,
  output logic                     wr_req,
  output logic [ADDR_W-1:0]        wr_addr,
  input  logic                     wr_ack,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int R  = (KSIZE - 1) / 2;
  localparam int KW = $clog2(KSIZE);
  localparam int CW = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H);

  localparam logic [KW-1:0]     K_LAST = KW'(KSIZE - 1);
  localparam logic [CW-1:0]     C_MIN  = CW'(R);
  localparam logic [CW-1:0]     X_MAX  = CW'(IMG_W - 1 - R);
  localparam logic [CW-1:0]     Y_MAX  = CW'(IMG_H - 1 - R);
  localparam logic [ADDR_W-1:0] A_R    = ADDR_W'(R);
  localparam logic [ADDR_W-1:0] A_W    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] A_OW   = ADDR_W'(IMG_W - 2 * R);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_FETCH, S_CALC, S_WAIT_CALC, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     x_q, x_d, y_q, y_d;
  logic [KW-1:0]     row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    row_d   = row_q;
    col_d   = col_q;
    if (state_q != S_IDLE && abort) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d = S_FETCH;
            x_d     = C_MIN;
            y_d     = C_MIN;
            row_d   = '0;
            col_d   = '0;
          end
        end
        S_SHIFT: state_d = S_FETCH;
        S_FETCH: begin
          // Shift mode enters with col at K_LAST, so the same walk ends after one column.
          if (rd_ack) begin
            if (row_q != K_LAST) begin
              row_d = row_q + 1'b1;
            end else if (col_q != K_LAST) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC:      state_d = S_WAIT_CALC;
        S_WAIT_CALC: if (calc_done) state_d = S_WRITE;
        S_WRITE:     if (wr_ack) state_d = S_ADVANCE;
        S_ADVANCE: begin
          if (x_q < X_MAX) begin
            state_d = S_SHIFT;
            x_d     = x_q + 1'b1;
            row_d   = '0;
            col_d   = K_LAST;
          end else if (y_q < Y_MAX) begin
            state_d = S_FETCH;
            x_d     = C_MIN;
            y_d     = y_q + 1'b1;
            row_d   = '0;
            col_d   = '0;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          x_d     = '0;
          y_d     = '0;
          row_d   = '0;
          col_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Addresses are derived from the next-state counters so they are registered alongside them.
  always_comb begin
    rd_addr_d = '0;
    wr_addr_d = '0;
    if (state_d != S_IDLE) begin
      rd_addr_d = IN_BASE + (ADDR_W'(y_d) + ADDR_W'(row_d) - A_R) * A_W
                + ADDR_W'(x_d) + ADDR_W'(col_d) - A_R;
      wr_addr_d = OUT_BASE + (ADDR_W'(y_d) - A_R) * A_OW + ADDR_W'(x_d) - A_R;
    end
  end

  always_comb begin
    rd_req     = (state_q == S_FETCH);
    win_wr_en  = (state_q == S_FETCH) && rd_ack && !abort;
    win_shift  = (state_q == S_SHIFT);
    calc_start = (state_q == S_CALC);
    wr_req     = (state_q == S_WRITE);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    rd_addr    = rd_addr_q;
    wr_addr    = wr_addr_q;
    win_row    = row_q;
    win_col    = col_q;
  end

endmodule
